// File: rtl/jk_bank_access_arbiter.sv
// Round-robin, two-requester controller for an external bank of master-slave JK flops.
// Each command drives J/K for one cycle, waits one cycle for the slave, then reports the bit.
module jk_bank_access_arbiter #(
  parameter int WIDTH = 8,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [1:0]       req0_op,
  input  logic [1:0]       req1_op,
  input  logic [IDX_W-1:0] req0_idx,
  input  logic [IDX_W-1:0] req1_idx,
  output logic [WIDTH-1:0] jk_j,
  output logic [WIDTH-1:0] jk_k,
  input  logic [WIDTH-1:0] q_in,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic             rsp_data,
  output logic             rsp_err,
  output logic             busy
);

  localparam logic [1:0] OP_SET    = 2'b01;
  localparam logic [1:0] OP_CLEAR  = 2'b10;
  localparam logic [1:0] OP_TOGGLE = 2'b11;
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DRIVE  = 2'd1,
    S_SETTLE = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic             prio_q, prio_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             id_q, id_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] jk_j_q, jk_j_d;
  logic [WIDTH-1:0] jk_k_q, jk_k_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_data_q, rsp_data_d;

  logic             grant_id;
  logic             accept;
  logic [1:0]       sel_op;
  logic [IDX_W-1:0] sel_idx;
  logic             sel_err;
  logic [WIDTH-1:0] sel_mask;
  logic [WIDTH-1:0] idx_mask;

  function automatic logic idx_oob(input logic [IDX_W-1:0] idx);
    return 32'(idx) >= 32'(WIDTH);
  endfunction

  // Shifts rather than bit-selects keep the index width independent of WIDTH.
  always_comb begin
    grant_id  = (req_valid == 2'b10) || ((req_valid == 2'b11) && prio_q);
    req_ready = 2'b00;
    if (!reset && (state_q == S_IDLE)) begin
      req_ready = {grant_id & req_valid[1], ~grant_id & req_valid[0]};
    end
    accept   = |req_ready;
    sel_op   = grant_id ? req1_op : req0_op;
    sel_idx  = grant_id ? req1_idx : req0_idx;
    sel_err  = idx_oob(sel_idx);
    sel_mask = sel_err ? '0 : (ONE << sel_idx);
    idx_mask = ONE << idx_q;
  end

  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    idx_d       = idx_q;
    id_d        = id_q;
    err_d       = err_q;
    jk_j_d      = '0;
    jk_k_d      = '0;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_DRIVE;
          prio_d  = ~grant_id;
          idx_d   = sel_idx;
          id_d    = grant_id;
          err_d   = sel_err;
          jk_j_d  = ((sel_op == OP_SET) || (sel_op == OP_TOGGLE)) ? sel_mask : '0;
          jk_k_d  = ((sel_op == OP_CLEAR) || (sel_op == OP_TOGGLE)) ? sel_mask : '0;
        end
      end
      S_DRIVE:  state_d = S_SETTLE;
      S_SETTLE: begin
        // The slave stage has updated on the falling edge inside this cycle.
        state_d     = S_RESP;
        rsp_valid_d = 1'b1;
        rsp_data_d  = !err_q && |(q_in & idx_mask);
      end
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      prio_q      <= 1'b0;
      jk_j_q      <= '0;
      jk_k_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      jk_j_q      <= jk_j_d;
      jk_k_q      <= jk_k_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  // Command fields are only consumed while busy, so they need no reset.
  always_ff @(posedge clk) begin
    idx_q <= idx_d;
    id_q  <= id_d;
    err_q <= err_d;
  end

  assign jk_j      = jk_j_q;
  assign jk_k      = jk_k_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_valid_q & id_q;
  assign rsp_err   = rsp_valid_q & err_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_jk_bank_access_arbiter.sv
// Bench for jk_bank_access_arbiter: JK bank model plus a transaction-level reference model.
module tb_jk_bank_access_arbiter;
  localparam int WIDTH = 8;
  localparam int IDX_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [1:0]       req0_op, req1_op;
  logic [IDX_W-1:0] req0_idx, req1_idx;
  logic [WIDTH-1:0] jk_j, jk_k, q_in;
  logic             rsp_valid, rsp_id, rsp_data, rsp_err, busy;

  always #5 clk = ~clk;

  jk_bank_access_arbiter #(.WIDTH(WIDTH), .IDX_W(IDX_W)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req0_op(req0_op), .req1_op(req1_op),
    .req0_idx(req0_idx), .req1_idx(req1_idx),
    .jk_j(jk_j), .jk_k(jk_k), .q_in(q_in),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .busy(busy)
  );

  // Master-slave JK bank: master captures on the rising edge, slave follows on the falling edge.
  logic [WIDTH-1:0] bank_m = '0;
  logic [WIDTH-1:0] bank_s = '0;
  assign q_in = bank_s;
  always @(posedge clk)
    if ((^{jk_j, jk_k}) !== 1'bx) bank_m <= (jk_j & ~bank_s) | (~jk_k & bank_s);
  always @(negedge clk) bank_s <= bank_m;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model state: bank contents, priority, and the last accepted command.
  bit               m_bits [WIDTH];
  int               m_prio = 0;
  bit               m_active = 1'b0;
  int               m_acc_e = 0;
  int               ecnt = 0;
  logic [WIDTH-1:0] m_j = '0, m_k = '0;
  bit               m_id, m_err, m_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, ecnt);
    end
  endtask

  task automatic cycle();
    logic [1:0]       exp_ready;
    logic [1:0]       op;
    logic [WIDTH-1:0] ej, ek;
    int               g, idx, age;
    bit               idle, acc, was_rst, nw;
    #1;
    idle = !m_active || ((ecnt - m_acc_e) >= 3);
    g = (req_valid == 2'b11) ? m_prio : (req_valid[1] ? 1 : 0);
    exp_ready = 2'b00;
    if (!reset && idle && (req_valid != 2'b00)) exp_ready = (g == 1) ? 2'b10 : 2'b01;
    chk("req_ready", 32'(req_ready), 32'(exp_ready));
    acc     = (exp_ready != 2'b00);
    op      = (g == 1) ? req1_op : req0_op;
    idx     = (g == 1) ? int'(req1_idx) : int'(req0_idx);
    was_rst = reset;
    @(posedge clk);
    ecnt++;
    if (was_rst) begin
      m_active = 1'b0;
      m_prio   = 0;
    end else if (acc) begin
      m_err = (idx >= WIDTH);
      m_id  = (g == 1);
      m_j   = '0;
      m_k   = '0;
      m_data = 1'b0;
      if (!m_err) begin
        case (op)
          2'b00:   nw = m_bits[idx];
          2'b01:   nw = 1'b1;
          2'b10:   nw = 1'b0;
          default: nw = ~m_bits[idx];
        endcase
        m_bits[idx] = nw;
        m_data = nw;
        if (op == 2'b01 || op == 2'b11) m_j[idx] = 1'b1;
        if (op == 2'b10 || op == 2'b11) m_k[idx] = 1'b1;
      end
      m_prio   = 1 - g;
      m_active = 1'b1;
      m_acc_e  = ecnt;
    end
    @(negedge clk);
    age = ecnt - m_acc_e;
    ej = (m_active && age == 0) ? m_j : '0;
    ek = (m_active && age == 0) ? m_k : '0;
    chk("jk_j", 32'(jk_j), 32'(ej));
    chk("jk_k", 32'(jk_k), 32'(ek));
    chk("rsp_valid", 32'(rsp_valid), 32'(m_active && age == 2));
    chk("busy", 32'(busy), 32'(m_active && age <= 2));
    if (m_active && age == 2) begin
      chk("rsp_id", 32'(rsp_id), 32'(m_id));
      chk("rsp_data", 32'(rsp_data), 32'(m_data));
      chk("rsp_err", 32'(rsp_err), 32'(m_err));
    end
    if (was_rst) begin
      chk("rst_rsp_data", 32'(rsp_data), 32'(0));
      chk("rst_rsp_id", 32'(rsp_id), 32'(0));
      chk("rst_rsp_err", 32'(rsp_err), 32'(0));
    end
  endtask

  task automatic idle_cycles(input int n);
    req_valid = 2'b00;
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    for (int i = 0; i < WIDTH; i++) m_bits[i] = 1'b0;
    reset = 1'b1; req_valid = 2'b11;
    req0_op = 2'b01; req1_op = 2'b00; req0_idx = 4'd5; req1_idx = 4'd7;

    // Reset held two cycles with both requesters asserting.
    cycle(); cycle();
    reset = 1'b0;

    // Both valid after release: requester 0 wins, SET idx 5.
    req_valid = 2'b11; req0_op = 2'b01; req0_idx = 4'd5;
    cycle();
    idle_cycles(4);

    // Contention on TOGGLE idx 3 from a fresh priority pointer.
    reset = 1'b1; cycle(); reset = 1'b0;
    req0_op = 2'b11; req1_op = 2'b11; req0_idx = 4'd3; req1_idx = 4'd3;
    req_valid = 2'b11;
    for (int i = 0; i < 16; i++) cycle();
    idle_cycles(2);

    // Out-of-range CLEAR from requester 1.
    req_valid = 2'b10; req1_op = 2'b10; req1_idx = 4'd9;
    cycle();
    idle_cycles(4);

    // Reset during DRIVE of SET idx 0.
    req_valid = 2'b01; req0_op = 2'b01; req0_idx = 4'd0;
    cycle();
    req_valid = 2'b00; reset = 1'b1;
    cycle();
    reset = 1'b0;
    idle_cycles(3);
    req_valid = 2'b11; req0_op = 2'b00; req1_op = 2'b00; req0_idx = 4'd0; req1_idx = 4'd0;
    cycle();
    idle_cycles(4);

    // SET bit 2 then READ it back.
    req_valid = 2'b10; req1_op = 2'b01; req1_idx = 4'd2;
    cycle();
    idle_cycles(4);
    req_valid = 2'b01; req0_op = 2'b00; req0_idx = 4'd2;
    cycle();
    idle_cycles(4);

    // Randomized traffic including occasional resets and out-of-range indices.
    for (int i = 0; i < 400; i++) begin
      reset     = ($urandom_range(0, 39) == 0);
      req_valid = 2'($urandom_range(0, 3));
      req0_op   = 2'($urandom_range(0, 3));
      req1_op   = 2'($urandom_range(0, 3));
      req0_idx  = 4'($urandom_range(0, 9));
      req1_idx  = 4'($urandom_range(0, 9));
      cycle();
    end
    reset = 1'b0;
    idle_cycles(4);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/jk_bank_access_arbiter.md
# jk_bank_access_arbiter

Two-requester round-robin controller that shares an external bank of `WIDTH` master-slave JK flip-flops. Each accepted command sets, clears, toggles or reads one bit. The block drives the bank's J/K vectors for exactly one cycle, waits for the slave stage to settle on the falling edge, then returns the post-operation bit value as a one-cycle response. It sits between software-visible request ports and the flop bank, and is the only driver of the bank's J/K inputs.

## Interface
Parameters:
- `WIDTH`, default 8: number of JK cells in the bank, legal range 2..256.
- `IDX_W`, default `$clog2(WIDTH)`: width of the bit-index field.

Ports:
- `clk` in 1: single clock, rising edge. The bank's slave stage updates on the falling edge of the same clock.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 2: request valid, one bit per requester (bit 0 is requester 0).
- `req_ready` out 2: request accepted; at most one bit high at a time.
- `req0_op`, `req1_op` in 2: command op. 00 = READ, 01 = SET, 10 = CLEAR, 11 = TOGGLE.
- `req0_idx`, `req1_idx` in `IDX_W`: target bit index.
- `jk_j` out `WIDTH`: J vector to the bank.
- `jk_k` out `WIDTH`: K vector to the bank.
- `q_in` in `WIDTH`: slave Q outputs of the bank.
- `rsp_valid` out 1: response strobe, high for one cycle.
- `rsp_id` out 1: requester that issued the responded command.
- `rsp_data` out 1: `q_in[idx]` after the operation completes.
- `rsp_err` out 1: index out of range (`idx >= WIDTH`).
- `busy` out 1: high in any state other than IDLE.

## Operation
- FSM states: IDLE → DRIVE → SETTLE → RESP → IDLE. Every command takes this full path, including READ and error commands.
- **IDLE**
  - `req_ready[g] = req_valid[g] & (g == grant)`.
  - Grant selection: if only one requester is valid, it wins. If both are valid, requester `prio` wins.
  - On handshake (`valid & ready`), latch op, idx and id, and go to DRIVE.
- **Priority pointer**
  - `prio` resets to 0.
  - After each accept, `prio` becomes the requester that was not granted. This makes the arbitration strictly alternating under contention.
- **DRIVE** (one cycle)
  - SET: `jk_j[idx] = 1`, `jk_k[idx] = 0`.
  - CLEAR: `jk_j[idx] = 0`, `jk_k[idx] = 1`.
  - TOGGLE: `jk_j[idx] = jk_k[idx] = 1`.
  - READ or out-of-range index: both vectors stay all-zero.
  - All other bits of both vectors are 0 at all times.
- **SETTLE** (one cycle)
  - J/K are all-zero.
  - The bank slave updates on the falling edge within this cycle.
  - On the rising edge that ends SETTLE, register `q_in[idx]` (or 0 on error) into `rsp_data`.
- **RESP** (one cycle)
  - `rsp_valid = 1`, with `rsp_id`, `rsp_data` and `rsp_err` valid.
  - There is no response backpressure.
- `jk_j` and `jk_k` are registered outputs, and are all-zero in every state except DRIVE.
- **Reset**, at any state or cycle:
  - Next state is IDLE and `prio` becomes 0.
  - `jk_j`, `jk_k`, `rsp_valid`, `rsp_id`, `rsp_data`, `rsp_err` and `busy` all become 0 at the following edge.
  - `req_ready` is forced to 0 while `reset` is high.
  - Any command in flight is dropped with no response. The bank contents are not touched by the controller.

## Timing
- Edge E0: handshake. DRIVE occupies E0..E1, and the bank master captures at E1.
- SETTLE occupies E1..E2, with the slave updating at the falling edge inside it.
- `rsp_valid` is high during E2..E3.
- At E3 the FSM is back in IDLE, so `req_ready` can be high in the E3..E4 cycle. The next accept is therefore at E4 at the earliest.
- Throughput: one command per 4 cycles. Latency from accept edge to response-valid edge is 2 cycles.
- `req_valid` is never required to be held after acceptance. Requester inputs are ignored outside IDLE.
- Simultaneous requests: the losing requester's `req_ready` stays 0. It is served at the next IDLE if it is still valid.

## Test plan
- **Reset values.** Hold `reset` for 2 cycles with both `req_valid` high. Expect all outputs 0 and `req_ready` = 00 throughout, and `prio` = 0 after release, so requester 0 is granted first.
- **SET bit.** Requester 0 issues SET idx 5, `WIDTH` = 8. Expect `jk_j` = 0x20 and `jk_k` = 0x00 for exactly one cycle, then `rsp_valid` 2 edges after accept with `rsp_id` = 0, `rsp_data` = 1, `rsp_err` = 0.
- **Contention.** Both requesters hold TOGGLE idx 3 continuously, with the bit starting at 0. Expect grants 0, 1, 0, 1, responses with `rsp_data` 1, 0, 1, 0, and accepts 4 cycles apart.
- **Out of range.** Requester 1 issues CLEAR idx 9 with `WIDTH` = 8 (`IDX_W` = 4). Expect J/K all-zero throughout, and a response with `rsp_err` = 1, `rsp_data` = 0, `rsp_id` = 1, with normal latency.
- **Reset mid-operation.** Assert `reset` during DRIVE of a SET idx 0. Expect J/K = 0 at the next edge, no `rsp_valid`, and IDLE with `prio` = 0 after release.
- **READ.** Set bit 2 to 1, then issue READ idx 2. Expect no J/K activity and `rsp_data` = 1.
